// File: rtl/wb_arb_pkg.sv
// Shared definitions for the two-master Wishbone arbiter: FSM state
// encoding, one-hot grant encodings and the default watchdog limit.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT0 = 2'd1,
        ST_GRANT1 = 2'd2,
        ST_ABORT  = 2'd3
    } arb_state_t;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_M0   = 2'b01;
    localparam logic [1:0] GNT_M1   = 2'b10;

    // Cycles of unanswered strobe tolerated before the transfer is aborted.
    localparam int unsigned TIMEOUT_CYC_DEF = 255;

endpackage

// File: rtl/wb_arb_watchdog.sv
// Bus watchdog: counts consecutive strobe cycles without a slave response
// and flags the cycle in which the count of unanswered cycles reaches the
// limit, so the arbiter can abort on the following edge.
module wb_arb_watchdog
    import wb_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF  // 1..255
) (
    input  logic i_clk,
    input  logic i_resetn,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam logic [7:0] TERM_CNT = 8'(TIMEOUT_CYC - 1);

    logic [7:0] cnt;

    // A response in the same cycle as the terminal count wins (clear has priority).
    assign expired = run && !clear && (cnt == TERM_CNT);

    // Unanswered-strobe counter, cleared by any response or while no grant is active
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            cnt <= 8'd0;
        end else if (clear) begin
            cnt <= 8'd0;
        end else if (run && !expired) begin
            cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/wb_master_arbiter.sv
// Two-master Wishbone arbiter with locked cycles, fair alternation under
// contention, one dead IDLE cycle between owners and a strobe watchdog that
// aborts a transfer the slave never answers.
module wb_master_arbiter
    import wb_arb_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic              i_clk,
    input  logic              i_resetn,
    input  logic [ADDR_W-1:0] m0_wb_adr_i,
    input  logic [DATA_W-1:0] m0_wb_dat_i,
    input  logic              m0_wb_we_i,
    input  logic [3:0]        m0_wb_sel_i,
    input  logic              m0_wb_stb_i,
    input  logic              m0_wb_cyc_i,
    output logic [DATA_W-1:0] m0_wb_dat_o,
    output logic              m0_wb_ack_o,
    output logic              m0_wb_err_o,
    input  logic [ADDR_W-1:0] m1_wb_adr_i,
    input  logic [DATA_W-1:0] m1_wb_dat_i,
    input  logic              m1_wb_we_i,
    input  logic [3:0]        m1_wb_sel_i,
    input  logic              m1_wb_stb_i,
    input  logic              m1_wb_cyc_i,
    output logic [DATA_W-1:0] m1_wb_dat_o,
    output logic              m1_wb_ack_o,
    output logic              m1_wb_err_o,
    output logic [ADDR_W-1:0] s_wb_adr_o,
    output logic [DATA_W-1:0] s_wb_dat_o,
    output logic              s_wb_we_o,
    output logic [3:0]        s_wb_sel_o,
    output logic              s_wb_stb_o,
    output logic              s_wb_cyc_o,
    input  logic [DATA_W-1:0] s_wb_dat_i,
    input  logic              s_wb_ack_i,
    input  logic              s_wb_err_i,
    output logic [1:0]        o_grant,
    output logic              o_timeout
);

    arb_state_t state;
    arb_state_t nxt_state;
    logic       last_m1;     // master 1 was served last
    logic       abort_m1;    // master 1 owned the aborted transfer
    logic       timeout_q;   // high only in the first ABORT cycle
    logic       granted;
    logic       wd_clear;
    logic       wd_expired;

    assign granted  = (state == ST_GRANT0) || (state == ST_GRANT1);
    assign wd_clear = !granted || s_wb_ack_i || s_wb_err_i;

    wb_arb_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .i_clk    (i_clk),
        .i_resetn (i_resetn),
        .clear    (wd_clear),
        .run      (s_wb_stb_o),
        .expired  (wd_expired)
    );

    // Read data is broadcast; only ack/err distinguish the owner.
    assign m0_wb_dat_o = s_wb_dat_i;
    assign m1_wb_dat_o = s_wb_dat_i;
    assign o_timeout   = timeout_q;

    // State register
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= nxt_state;
        end
    end

    // Fairness history, aborted owner and the one-cycle timeout pulse
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            last_m1   <= 1'b1;
            abort_m1  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= granted && wd_expired;
            case (state)
                ST_GRANT0: begin
                    if (nxt_state == ST_IDLE)  last_m1  <= 1'b0;
                    if (nxt_state == ST_ABORT) abort_m1 <= 1'b0;
                end
                ST_GRANT1: begin
                    if (nxt_state == ST_IDLE)  last_m1  <= 1'b1;
                    if (nxt_state == ST_ABORT) abort_m1 <= 1'b1;
                end
                ST_ABORT: begin
                    if (nxt_state == ST_IDLE)  last_m1  <= abort_m1;
                end
                default: ;
            endcase
        end
    end

    // Next-state: arbitrate from IDLE, hold locked cycles, abort on watchdog expiry
    always_comb begin
        nxt_state = state;
        case (state)
            ST_IDLE: begin
                if (m0_wb_cyc_i && m1_wb_cyc_i) begin
                    nxt_state = last_m1 ? ST_GRANT0 : ST_GRANT1;
                end else if (m0_wb_cyc_i) begin
                    nxt_state = ST_GRANT0;
                end else if (m1_wb_cyc_i) begin
                    nxt_state = ST_GRANT1;
                end
            end
            ST_GRANT0: begin
                if (wd_expired)        nxt_state = ST_ABORT;
                else if (!m0_wb_cyc_i) nxt_state = ST_IDLE;
            end
            ST_GRANT1: begin
                if (wd_expired)        nxt_state = ST_ABORT;
                else if (!m1_wb_cyc_i) nxt_state = ST_IDLE;
            end
            ST_ABORT: begin
                if (abort_m1 ? !m1_wb_cyc_i : !m0_wb_cyc_i) nxt_state = ST_IDLE;
            end
            default: nxt_state = ST_IDLE;
        endcase
    end

    // Outputs: route the owner's request to the bus and the bus response to the owner
    always_comb begin
        s_wb_adr_o  = '0;
        s_wb_dat_o  = '0;
        s_wb_we_o   = 1'b0;
        s_wb_sel_o  = 4'h0;
        s_wb_stb_o  = 1'b0;
        s_wb_cyc_o  = 1'b0;
        m0_wb_ack_o = 1'b0;
        m0_wb_err_o = 1'b0;
        m1_wb_ack_o = 1'b0;
        m1_wb_err_o = 1'b0;
        o_grant     = GNT_NONE;
        case (state)
            ST_GRANT0: begin
                s_wb_adr_o  = m0_wb_adr_i;
                s_wb_dat_o  = m0_wb_dat_i;
                s_wb_we_o   = m0_wb_we_i;
                s_wb_sel_o  = m0_wb_sel_i;
                s_wb_stb_o  = m0_wb_stb_i;
                s_wb_cyc_o  = m0_wb_cyc_i;
                m0_wb_ack_o = s_wb_ack_i;
                m0_wb_err_o = s_wb_err_i;
                o_grant     = GNT_M0;
            end
            ST_GRANT1: begin
                s_wb_adr_o  = m1_wb_adr_i;
                s_wb_dat_o  = m1_wb_dat_i;
                s_wb_we_o   = m1_wb_we_i;
                s_wb_sel_o  = m1_wb_sel_i;
                s_wb_stb_o  = m1_wb_stb_i;
                s_wb_cyc_o  = m1_wb_cyc_i;
                m1_wb_ack_o = s_wb_ack_i;
                m1_wb_err_o = s_wb_err_i;
                o_grant     = GNT_M1;
            end
            ST_ABORT: begin
                // Late slave responses are dropped; only the abort error reaches the owner.
                m0_wb_err_o = timeout_q && !abort_m1;
                m1_wb_err_o = timeout_q && abort_m1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Bench for wb_master_arbiter: a cycle-by-cycle vector table for the basic
// routing behaviour plus hand-written sequences for alternation, locked
// bursts, watchdog abort, ack at terminal count and reset mid-transfer.
module tb_wb_master_arbiter;

    localparam logic [31:0] M0A = 32'h1122_3344;
    localparam logic [31:0] M1A = 32'hA000_0040;

    logic        i_clk = 1'b0;
    logic        i_resetn = 1'b0;
    logic [31:0] m0_wb_adr_i, m0_wb_dat_i, m1_wb_adr_i, m1_wb_dat_i;
    logic        m0_wb_we_i, m0_wb_stb_i, m0_wb_cyc_i;
    logic        m1_wb_we_i, m1_wb_stb_i, m1_wb_cyc_i;
    logic [3:0]  m0_wb_sel_i, m1_wb_sel_i;
    logic [31:0] m0_wb_dat_o, m1_wb_dat_o;
    logic        m0_wb_ack_o, m0_wb_err_o, m1_wb_ack_o, m1_wb_err_o;
    logic [31:0] s_wb_adr_o, s_wb_dat_o, s_wb_dat_i;
    logic        s_wb_we_o, s_wb_stb_o, s_wb_cyc_o, s_wb_ack_i, s_wb_err_i;
    logic [3:0]  s_wb_sel_o;
    logic [1:0]  o_grant;
    logic        o_timeout;

    int n_checks = 0;
    int n_err    = 0;

    always #5 i_clk = ~i_clk;

    wb_master_arbiter #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .TIMEOUT_CYC (8)
    ) dut (
        .i_clk       (i_clk),
        .i_resetn    (i_resetn),
        .m0_wb_adr_i (m0_wb_adr_i),
        .m0_wb_dat_i (m0_wb_dat_i),
        .m0_wb_we_i  (m0_wb_we_i),
        .m0_wb_sel_i (m0_wb_sel_i),
        .m0_wb_stb_i (m0_wb_stb_i),
        .m0_wb_cyc_i (m0_wb_cyc_i),
        .m0_wb_dat_o (m0_wb_dat_o),
        .m0_wb_ack_o (m0_wb_ack_o),
        .m0_wb_err_o (m0_wb_err_o),
        .m1_wb_adr_i (m1_wb_adr_i),
        .m1_wb_dat_i (m1_wb_dat_i),
        .m1_wb_we_i  (m1_wb_we_i),
        .m1_wb_sel_i (m1_wb_sel_i),
        .m1_wb_stb_i (m1_wb_stb_i),
        .m1_wb_cyc_i (m1_wb_cyc_i),
        .m1_wb_dat_o (m1_wb_dat_o),
        .m1_wb_ack_o (m1_wb_ack_o),
        .m1_wb_err_o (m1_wb_err_o),
        .s_wb_adr_o  (s_wb_adr_o),
        .s_wb_dat_o  (s_wb_dat_o),
        .s_wb_we_o   (s_wb_we_o),
        .s_wb_sel_o  (s_wb_sel_o),
        .s_wb_stb_o  (s_wb_stb_o),
        .s_wb_cyc_o  (s_wb_cyc_o),
        .s_wb_dat_i  (s_wb_dat_i),
        .s_wb_ack_i  (s_wb_ack_i),
        .s_wb_err_i  (s_wb_err_i),
        .o_grant     (o_grant),
        .o_timeout   (o_timeout)
    );

    typedef struct {
        logic        c0, c1, ack, err;
        logic [31:0] sdat;
        logic [1:0]  gnt;
        logic        scyc;
        logic [31:0] sadr;
        logic [3:0]  resp;   // {m0_ack, m1_ack, m0_err, m1_err}
    } vec_t;

    vec_t tbl[16];

    function automatic vec_t mk(input logic c0, input logic c1, input logic ack,
                                input logic err, input logic [31:0] sdat,
                                input logic [1:0] gnt, input logic scyc,
                                input logic [31:0] sadr, input logic [3:0] resp);
        vec_t v;
        v.c0 = c0; v.c1 = c1; v.ack = ack; v.err = err; v.sdat = sdat;
        v.gnt = gnt; v.scyc = scyc; v.sadr = sadr; v.resp = resp;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc_step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_resetn    = 1'b0;
        m0_wb_cyc_i = 0; m0_wb_stb_i = 0; m0_wb_we_i = 0;
        m1_wb_cyc_i = 0; m1_wb_stb_i = 0; m1_wb_we_i = 0;
        m0_wb_adr_i = M0A; m0_wb_dat_i = 32'h0; m0_wb_sel_i = 4'hF;
        m1_wb_adr_i = M1A; m1_wb_dat_i = 32'h0; m1_wb_sel_i = 4'h3;
        s_wb_ack_i  = 0; s_wb_err_i = 0; s_wb_dat_i = 32'h0;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_resetn = 1'b1;
    endtask

    task automatic set_m0(input logic c);
        m0_wb_cyc_i = c; m0_wb_stb_i = c;
    endtask

    task automatic set_m1(input logic c);
        m1_wb_cyc_i = c; m1_wb_stb_i = c;
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        logic [1:0]  alt_exp [4];
        logic [31:0] beat [4];

        tbl[0]  = mk(0,0,0,0,32'h0,        2'b00,0,32'h0,4'b0000);
        tbl[1]  = mk(1,0,0,0,32'h0,        2'b00,0,32'h0,4'b0000);
        tbl[2]  = mk(1,0,0,0,32'h0,        2'b01,1,M0A,  4'b0000);
        tbl[3]  = mk(1,0,0,0,32'h0,        2'b01,1,M0A,  4'b0000);
        tbl[4]  = mk(1,0,1,0,32'hFFEEDDCC, 2'b01,1,M0A,  4'b1000);
        tbl[5]  = mk(0,0,0,0,32'h0,        2'b01,0,M0A,  4'b0000);
        tbl[6]  = mk(0,0,0,0,32'h0,        2'b00,0,32'h0,4'b0000);
        tbl[7]  = mk(0,0,1,0,32'h12345678, 2'b00,0,32'h0,4'b0000);
        tbl[8]  = mk(1,1,0,0,32'h0,        2'b00,0,32'h0,4'b0000);
        tbl[9]  = mk(1,1,0,0,32'h0,        2'b10,1,M1A,  4'b0000);
        tbl[10] = mk(1,0,0,0,32'h0,        2'b10,0,M1A,  4'b0000);
        tbl[11] = mk(1,0,0,0,32'h0,        2'b00,0,32'h0,4'b0000);
        tbl[12] = mk(1,0,0,0,32'h0,        2'b01,1,M0A,  4'b0000);
        tbl[13] = mk(1,0,1,1,32'hCAFEF00D, 2'b01,1,M0A,  4'b1010);
        tbl[14] = mk(0,0,0,0,32'h0,        2'b01,0,M0A,  4'b0000);
        tbl[15] = mk(0,1,0,1,32'h0,        2'b00,0,32'h0,4'b0000);

        do_reset();
        i_resetn = 1'b0;
        #1;
        check("reset_grant", 64'(o_grant), 64'(2'b00));
        check("reset_cyc", 64'({s_wb_cyc_o, s_wb_stb_o, o_timeout}), 64'(3'b000));
        do_reset();

        // Table: one vector per clock cycle
        for (int i = 0; i < 16; i++) begin
            cyc_step();
            set_m0(tbl[i].c0);
            set_m1(tbl[i].c1);
            m1_wb_we_i = tbl[i].c1;
            s_wb_ack_i = tbl[i].ack;
            s_wb_err_i = tbl[i].err;
            s_wb_dat_i = tbl[i].sdat;
            #1;
            check($sformatf("v%0d_grant", i), 64'(o_grant), 64'(tbl[i].gnt));
            check($sformatf("v%0d_scyc", i), 64'(s_wb_cyc_o), 64'(tbl[i].scyc));
            check($sformatf("v%0d_sadr", i), 64'(s_wb_adr_o), 64'(tbl[i].sadr));
            check($sformatf("v%0d_resp", i),
                  64'({m0_wb_ack_o, m1_wb_ack_o, m0_wb_err_o, m1_wb_err_o}), 64'(tbl[i].resp));
            check($sformatf("v%0d_dat", i), 64'({m0_wb_dat_o, m1_wb_dat_o}),
                  {tbl[i].sdat, tbl[i].sdat});
            check($sformatf("v%0d_tmo", i), 64'(o_timeout), 64'(0));
        end

        // Alternation under joint contention, starting with m0 after reset
        do_reset();
        alt_exp[0] = 2'b01; alt_exp[1] = 2'b10; alt_exp[2] = 2'b01; alt_exp[3] = 2'b10;
        for (int r = 0; r < 4; r++) begin
            cyc_step(); set_m0(1); set_m1(1); #1;
            check($sformatf("alt%0d_idle", r), 64'({o_grant, s_wb_cyc_o}), 64'(3'b000));
            cyc_step(); #1;
            check($sformatf("alt%0d_grant", r), 64'({o_grant, s_wb_cyc_o}), 64'({alt_exp[r], 1'b1}));
            cyc_step(); set_m0(0); set_m1(0);
        end

        // Locked 4-beat write burst by m1 while m0 waits
        beat[0] = 32'h55; beat[1] = 32'h66; beat[2] = 32'h77; beat[3] = 32'h88;
        cyc_step(); set_m1(1); m1_wb_we_i = 1; m1_wb_dat_i = beat[0]; #1;
        check("burst_idle", 64'(o_grant), 64'(2'b00));
        for (int b = 0; b < 4; b++) begin
            cyc_step(); set_m0(1); m1_wb_dat_i = beat[b]; s_wb_ack_i = 1; #1;
            check($sformatf("burst%0d", b),
                  64'({o_grant, s_wb_we_o, s_wb_sel_o, s_wb_dat_o}),
                  64'({2'b10, 1'b1, 4'h3, beat[b]}));
            check($sformatf("burst%0d_ack", b), 64'({m0_wb_ack_o, m1_wb_ack_o}), 64'(2'b01));
        end
        cyc_step(); set_m1(0); m1_wb_we_i = 0; s_wb_ack_i = 0; #1;
        check("burst_drop", 64'({o_grant, s_wb_cyc_o}), 64'({2'b10, 1'b0}));
        cyc_step(); #1;
        check("burst_dead", 64'({o_grant, s_wb_cyc_o}), 64'(3'b000));
        cyc_step(); #1;
        check("burst_m0", 64'({o_grant, s_wb_cyc_o, s_wb_adr_o}), 64'({2'b01, 1'b1, M0A}));
        cyc_step(); set_m0(0);

        // Watchdog: slave silent, abort after 8 unanswered strobe cycles
        cyc_step(); set_m0(1); #1;
        check("wd_idle", 64'(o_grant), 64'(2'b00));
        for (int k = 1; k <= 8; k++) begin
            cyc_step(); #1;
            check($sformatf("wd_stb%0d", k),
                  64'({s_wb_stb_o, o_timeout, m0_wb_err_o}), 64'(3'b100));
        end
        cyc_step(); #1;
        check("wd_abort", 64'({o_grant, s_wb_cyc_o, s_wb_stb_o, o_timeout, m0_wb_err_o, m1_wb_err_o}),
              64'({2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0}));
        cyc_step(); s_wb_ack_i = 1; #1;
        check("wd_late_ack", 64'({o_grant, s_wb_cyc_o, o_timeout, m0_wb_err_o, m0_wb_ack_o}),
              64'(6'b000000));
        s_wb_ack_i = 0;
        for (int k = 0; k < 3; k++) begin
            cyc_step(); #1;
            check($sformatf("wd_hold%0d", k), 64'({o_grant, s_wb_cyc_o, o_timeout}), 64'(4'b0000));
        end
        cyc_step(); set_m0(0);
        cyc_step(); set_m0(1); set_m1(1); #1;
        check("wd_exit_idle", 64'(o_grant), 64'(2'b00));
        cyc_step(); #1;
        check("wd_last_grant", 64'(o_grant), 64'(2'b10));
        cyc_step(); set_m0(0); set_m1(0);

        // Ack arriving exactly at the terminal count suppresses the abort
        cyc_step(); set_m0(1);
        for (int k = 1; k <= 8; k++) begin
            cyc_step();
            s_wb_ack_i = (k == 8);
            #1;
        end
        check("tc_ack_pass", 64'({m0_wb_ack_o, o_timeout}), 64'(2'b10));
        for (int k = 9; k <= 16; k++) begin
            cyc_step(); s_wb_ack_i = 0; #1;
            check($sformatf("tc_cnt%0d", k), 64'({o_grant, s_wb_stb_o, o_timeout}), 64'({2'b01, 1'b1, 1'b0}));
        end
        cyc_step(); #1;
        check("tc_abort_later", 64'({o_grant, o_timeout, m0_wb_err_o}), 64'({2'b00, 1'b1, 1'b1}));
        cyc_step(); set_m0(0);
        cyc_step();

        // Reset during an m1 transfer, with m0 served last beforehand
        cyc_step(); set_m1(1); #1;
        check("rst_pre_idle", 64'(o_grant), 64'(2'b00));
        cyc_step(); s_wb_ack_i = 1; s_wb_err_i = 1; #1;
        check("rst_pre_grant", 64'({o_grant, s_wb_cyc_o, m1_wb_ack_o}), 64'({2'b10, 1'b1, 1'b1}));
        i_resetn = 1'b0;
        #1;
        check("rst_async", 64'({o_grant, s_wb_cyc_o, s_wb_stb_o}), 64'(4'b0000));
        check("rst_no_resp", 64'({m0_wb_ack_o, m0_wb_err_o, m1_wb_ack_o, m1_wb_err_o, o_timeout}),
              64'(5'b00000));
        set_m0(1);
        s_wb_ack_i = 0; s_wb_err_i = 0;
        cyc_step(); #1;
        check("rst_held", 64'(o_grant), 64'(2'b00));
        @(negedge i_clk);
        i_resetn = 1'b1;
        cyc_step(); #1;
        check("rst_m0_wins", 64'({o_grant, s_wb_cyc_o, s_wb_adr_o}), 64'({2'b01, 1'b1, M0A}));
        cyc_step(); set_m0(0); set_m1(0);
        cyc_step();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/wb_master_arbiter.md
WB_MASTER_ARBITER -- requirements
Module: wb_master_arbiter

Interface
REQ-001 Parameters SHALL be, one per line:
- ADDR_W, 32, wishbone address width
- DATA_W, 32, wishbone data width
- TIMEOUT_CYC, 255, cycles of unanswered strobe before abort (1..255)
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- i_clk  in  1  single clock for all logic
- i_resetn  in  1  asynchronous active-low reset
- m0_wb_adr_i/dat_i/we_i/sel_i/stb_i/cyc_i  in  ADDR_W/DATA_W/1/4/1/1  master 0 request (SPI bridge)
- m0_wb_dat_o/ack_o/err_o  out  DATA_W/1/1  master 0 response
- m1_wb_adr_i/dat_i/we_i/sel_i/stb_i/cyc_i  in  ADDR_W/DATA_W/1/4/1/1  master 1 request
- m1_wb_dat_o/ack_o/err_o  out  DATA_W/1/1  master 1 response
- s_wb_adr_o/dat_o/we_o/sel_o/stb_o/cyc_o  out  ADDR_W/DATA_W/1/4/1/1  shared bus request
- s_wb_dat_i/ack_i/err_i  in  DATA_W/1/1  shared bus response
- o_grant  out  2  one-hot current owner (bit0 = m0, bit1 = m1), 00 when idle
- o_timeout  out  1  one-cycle pulse when a transfer is aborted

Function
REQ-003 FSM states SHALL be IDLE, GRANT0, GRANT1, ABORT; state is registered.
REQ-004 IDLE: if exactly one mN_wb_cyc_i is high, next state is GRANTn; if both are high, grant the master not served last (last_grant register).
REQ-005 Arbitration latency SHALL be one cycle: request seen in IDLE, s_wb_cyc_o asserted the following cycle.
REQ-006 GRANTn: s_wb_* request outputs SHALL combinationally follow master n; other master's requests are ignored.
REQ-007 Grant SHALL be held while mN_wb_cyc_i stays high (locked multi-beat cycles); when it drops, next state IDLE and last_grant <= n.
REQ-008 A cycle dropping in GRANTn while the other master requests SHALL pass through IDLE (one dead cycle, no back-to-back handover).
REQ-009 s_wb_ack_i/s_wb_err_i SHALL route only to the granted master; non-granted ack_o/err_o SHALL be 0.
REQ-010 mN_wb_dat_o SHALL be s_wb_dat_i for both masters (broadcast).
REQ-011 In IDLE and ABORT, s_wb_cyc_o, s_wb_stb_o, s_wb_we_o SHALL be 0, s_wb_sel_o 0, s_wb_adr_o/dat_o 0.
REQ-012 Watchdog: 8-bit counter cleared in IDLE and on any cycle with ack_i or err_i; increments each cycle s_wb_stb_o is high without response.
REQ-013 When counter reaches TIMEOUT_CYC, the next cycle SHALL: enter ABORT, pulse granted master's err_o and o_timeout for exactly one cycle, drop s_wb_cyc_o/stb_o.
REQ-014 ABORT SHALL persist until the aborted master drops cyc_i, then IDLE with last_grant updated; late s_wb_ack_i in ABORT SHALL be discarded.
REQ-015 Simultaneous ack_i and timeout terminal count: ack wins, counter clears, no abort.
REQ-016 Simultaneous ack_i and err_i SHALL both pass through unmodified.
REQ-017 o_grant SHALL reflect the state: 01 in GRANT0, 10 in GRANT1, 00 in IDLE/ABORT.

Reset
REQ-018 Asserting i_resetn low SHALL asynchronously force IDLE, counter 0, last_grant = m1 (so m0 wins first contention), o_timeout 0.
REQ-019 Reset mid-transfer SHALL drop s_wb_cyc_o/stb_o immediately with no ack/err emitted to any master.
REQ-020 Release of reset SHALL take effect on the next i_clk rising edge.

Structure
REQ-021 Package wb_arb_pkg SHALL hold the state encoding, the grant encoding constants and the default TIMEOUT_CYC.
REQ-022 The watchdog counter SHALL be a sub-module wb_arb_watchdog (inputs clear/run, output expired); remainder is flat.

Verification
REQ-023 m0 single read adr 0x11223344, slave acks after 2 cycles with 0xFFEEDDCC -> m0_wb_ack_o one cycle, m0_wb_dat_o 0xFFEEDDCC, m1 ack 0.
REQ-024 m0 and m1 raise cyc same cycle after reset -> GRANT0 first; next joint contention -> GRANT1 (alternation over 4 rounds).
REQ-025 m1 holds cyc for 4 writes (0x55,0x66,0x77,0x88) while m0 requests -> m0 not granted until m1 cyc drops plus one IDLE cycle.
REQ-026 Slave never acks, TIMEOUT_CYC=8 -> err_o and o_timeout pulse at stb cycle 9, s_wb_cyc_o low, ABORT held until master drops cyc.
REQ-027 i_resetn low during m1 transfer -> s_wb_cyc_o 0 same cycle, o_grant 00, no ack/err; after release m0 wins contention.
